uart_tx_arbiter: RTL and testbench

Shares one UART transmitter among N_REQ byte producers. The block arbitrates round-robin, latches the winning byte, and issues a one-cycle write to the transmitter. It then tracks the transmitter's busy signal until the frame completes. It sits between the producer blocks (command responder, debug printer, status reporter) and the transmitter, and drives the transmitter's wr_en and data_in.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART transmit arbiter slice.
//   tx_state_t   : arbiter FSM states (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE)
//   BYTE_W       : width of one UART payload byte
//   BUSY_TIMEOUT : cycles allowed for the transmitter to raise busy after a write
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin picker. Searches req upward starting at ptr,
// wrapping from N_REQ-1 back to 0, and returns the first requester found.
// Ports:
//   req     in  N_REQ  request vector
//   ptr     in  IDX_W  position with highest priority this cycle
//   gnt     out N_REQ  one-hot grant (all zero when nothing requests)
//   gnt_idx out IDX_W  index of the granted requester
//   any_gnt out 1      at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  // Position reached after stepping offs places past base, modulo N_REQ.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDX_W'(sum);
  endfunction

  // Walk from the farthest position back toward ptr so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr, k)]) begin
        gnt                  = '0;
        gnt[rot_idx(ptr, k)] = 1'b1;
        gnt_idx              = rot_idx(ptr, k);
        any_gnt              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte producers. Picks a winner
// round-robin, latches its byte, pulses the transmitter write strobe for one
// cycle and then follows the transmitter busy flag until the frame is done.
// A write that never produces busy within BUSY_TIMEOUT cycles raises the
// sticky proto_err and the byte is dropped.
// Optional feature macro: UART_TX_ARB_LOCK_EN adds req_last and keeps the
// grant on one requester until it sends a byte marked last.
// Ports:
//   clk, rst   in       clock; synchronous active-high reset
//   req_valid  in N_REQ    byte pending per requester
//   req_data   in 8*N_REQ  byte of requester i in bits [8i+7:8i]
//   req_last   in N_REQ    last byte of a message (UART_TX_ARB_LOCK_EN only)
//   req_ready  out N_REQ   one-cycle accept pulse to the grantee
//   tx_wr_en   out 1       one-cycle write strobe to the transmitter
//   tx_data    out 8       byte to the transmitter, held until next accept
//   tx_busy    in 1        transmitter busy flag
//   grant_idx  out IDX_W   current or last grantee
//   active     out 1       accept until transmitter busy falls
//   proto_err  out 1       sticky: busy never seen after a write
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_wr_en,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    active,
  output logic                    proto_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t          state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
  logic [N_REQ-1:0]   req_ready_n;
  logic               tx_wr_en_n;
  logic [BYTE_W-1:0]  tx_data_n;
  logic [IDX_W-1:0]   grant_idx_n;
  logic               active_n;
  logic               proto_err_n;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [N_REQ-1:0]   sel_onehot;

`ifdef UART_TX_ARB_LOCK_EN
  logic               locked, locked_n;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // Candidate for this IDLE cycle. While a multi-byte message is locked the
  // arbiter result is ignored and only the locked requester (held in
  // grant_idx) can win, even if it currently has nothing pending.
  always_comb begin
    sel_valid  = arb_any;
    sel_idx    = arb_idx;
    sel_onehot = arb_gnt;
`ifdef UART_TX_ARB_LOCK_EN
    if (locked) begin
      sel_valid           = req_valid[grant_idx];
      sel_idx             = grant_idx;
      sel_onehot          = '0;
      sel_onehot[grant_idx] = 1'b1;
    end
`endif
  end

  // Next-state and next-output logic. Strobes default low so they last
  // exactly one cycle; everything else holds unless a state changes it.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    wait_cnt_n  = wait_cnt;
    req_ready_n = '0;
    tx_wr_en_n  = 1'b0;
    tx_data_n   = tx_data;
    grant_idx_n = grant_idx;
    active_n    = active;
    proto_err_n = proto_err;
`ifdef UART_TX_ARB_LOCK_EN
    locked_n    = locked;
`endif
    case (state)
      IDLE: begin
        if (sel_valid && !tx_busy) begin
          tx_data_n   = req_data[sel_idx*BYTE_W +: BYTE_W];
          tx_wr_en_n  = 1'b1;
          req_ready_n = sel_onehot;
          grant_idx_n = sel_idx;
          active_n    = 1'b1;
          state_n     = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
          locked_n    = !req_last[sel_idx];
          if (!locked)
            rr_ptr_n = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
`else
          rr_ptr_n = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
`endif
        end
      end
      ISSUE: begin
        wait_cnt_n = '0;
        state_n    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (wait_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          proto_err_n = 1'b1;
          active_n    = 1'b0;
          state_n     = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          active_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs. Reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      req_ready <= '0;
      tx_wr_en  <= 1'b0;
      tx_data   <= '0;
      grant_idx <= '0;
      active    <= 1'b0;
      proto_err <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      wait_cnt  <= wait_cnt_n;
      req_ready <= req_ready_n;
      tx_wr_en  <= tx_wr_en_n;
      tx_data   <= tx_data_n;
      grant_idx <= grant_idx_n;
      active    <= active_n;
      proto_err <= proto_err_n;
`ifdef UART_TX_ARB_LOCK_EN
      locked    <= locked_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4). Requester models hold each
// byte until its ready pulse, a transmitter stub raises busy for a frame
// after each write, and a scoreboard of expected (grantee, byte) pairs is
// compared against every tx_wr_en pulse. The lock scenario is built only
// when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 10;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         tx_wr_en;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic [1:0]   grant_idx;
  logic         active;
  logic         proto_err;

  int total = 0;
  int bad   = 0;

  logic [9:0] sb_q[$];
  logic [8:0] rq_mem[N][8];
  int         rq_wr[N];
  int         rq_rd[N];

  logic force_busy  = 1'b0;
  logic stub_silent = 1'b0;
  int   frame_left  = 0;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .tx_wr_en  (tx_wr_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_idx (grant_idx),
    .active    (active),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input logic [1:0] idx, input logic [7:0] data);
    sb_q.push_back({idx, data});
  endtask

  // Queue a byte on requester i; present it at once if the requester is idle.
  task automatic apply_stimulus(input int i, input logic [7:0] data,
                                input logic last);
    if (!req_valid[i] && rq_rd[i] == rq_wr[i]) begin
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = data;
      req_last[i]        = last;
    end
    rq_mem[i][rq_wr[i]] = {last, data};
    rq_wr[i]++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || active === 1'b1 || tx_busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester models: drop valid on the ready pulse, present the next
  // queued byte on a later cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1) begin
          rq_rd[i]++;
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && rq_rd[i] < rq_wr[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq_mem[i][rq_rd[i]][7:0];
          req_last[i]        = rq_mem[i][rq_rd[i]][8];
        end
      end
    end
  end

  // Transmitter stub: busy for FRAME cycles starting the cycle after the
  // write strobe is sampled; cleared by the shared reset.
  initial begin
    logic wr, rs;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      wr = tx_wr_en;
      rs = rst;
      #1;
      if (rs) frame_left = 0;
      else begin
        if (frame_left > 0) frame_left--;
        if (wr && !stub_silent) frame_left = FRAME;
      end
      tx_busy = force_busy || (frame_left > 0);
    end
  end

  // Scoreboard monitor: every write strobe must match the oldest expectation
  // and must not land inside a busy period.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (tx_wr_en === 1'b1) begin
        check_output("wr_expected", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_output("sb_data", tx_data, e[7:0]);
          check_output("sb_grant", grant_idx, e[9:8]);
          check_output("sb_ready", req_ready, 4'b0001 << e[9:8]);
          check_output("sb_no_overlap", tx_busy, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [3:0] seen;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      rq_wr[i] = 0;
      rq_rd[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset values");
    check_output("rst_ready", req_ready, 4'b0000);
    check_output("rst_wr_en", tx_wr_en, 1'b0);
    check_output("rst_data", tx_data, 8'h00);
    check_output("rst_grant", grant_idx, 2'd0);
    check_output("rst_active", active, 1'b0);
    check_output("rst_proto_err", proto_err, 1'b0);

    $display("[TB] single byte");
    @(negedge clk);
    expect_grant(2'd2, 8'hA5);
    apply_stimulus(2, 8'hA5, 1'b1);
    @(negedge clk);
    check_output("single_wr_en", tx_wr_en, 1'b1);
    check_output("single_ready", req_ready, 4'b0100);
    check_output("single_data", tx_data, 8'hA5);
    check_output("single_grant", grant_idx, 2'd2);
    check_output("single_active", active, 1'b1);
    @(negedge clk);
    check_output("single_wr_clear", tx_wr_en, 1'b0);
    check_output("single_ready_clear", req_ready, 4'b0000);
    check_output("single_data_hold", tx_data, 8'hA5);
    wait_idle("single_done", 100);
    check_output("single_inactive", active, 1'b0);

    $display("[TB] contention");
    do_reset();
    expect_grant(2'd0, 8'h10);
    expect_grant(2'd1, 8'h11);
    expect_grant(2'd2, 8'h12);
    expect_grant(2'd3, 8'h13);
    expect_grant(2'd0, 8'h20);
    apply_stimulus(0, 8'h10, 1'b1);
    apply_stimulus(1, 8'h11, 1'b1);
    apply_stimulus(2, 8'h12, 1'b1);
    apply_stimulus(3, 8'h13, 1'b1);
    apply_stimulus(0, 8'h20, 1'b1);
    wait_idle("contention_done", 300);

    $display("[TB] busy gate");
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    expect_grant(2'd1, 8'h77);
    apply_stimulus(1, 8'h77, 1'b1);
    seen = '0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | req_ready | {3'b000, tx_wr_en};
    end
    check_output("gate_blocked", seen, 4'b0000);
    force_busy = 1'b0;
    tx_busy    = 1'b0;
    @(negedge clk);
    check_output("gate_accept", req_ready, 4'b0010);
    wait_idle("gate_done", 100);

    $display("[TB] protocol error");
    stub_silent = 1'b1;
    expect_grant(2'd3, 8'h3C);
    apply_stimulus(3, 8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check_output("perr_not_yet", proto_err, 1'b0);
    check_output("perr_active_hold", active, 1'b1);
    @(negedge clk);
    check_output("perr_set", proto_err, 1'b1);
    check_output("perr_active_clear", active, 1'b0);
    stub_silent = 1'b0;
    expect_grant(2'd0, 8'h5A);
    apply_stimulus(0, 8'h5A, 1'b1);
    wait_idle("perr_next_served", 100);
    check_output("perr_sticky", proto_err, 1'b1);

    $display("[TB] reset mid-frame");
    expect_grant(2'd2, 8'hC3);
    apply_stimulus(2, 8'hC3, 1'b1);
    begin
      int n = 0;
      while (tx_busy !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_output("mid_busy_seen", tx_busy, 1'b1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_ready", req_ready, 4'b0000);
    check_output("mid_wr_en", tx_wr_en, 1'b0);
    check_output("mid_data", tx_data, 8'h00);
    check_output("mid_grant", grant_idx, 2'd0);
    check_output("mid_active", active, 1'b0);
    check_output("mid_proto_err", proto_err, 1'b0);
    expect_grant(2'd1, 8'hB1);
    expect_grant(2'd3, 8'hB3);
    apply_stimulus(1, 8'hB1, 1'b1);
    apply_stimulus(3, 8'hB3, 1'b1);
    wait_idle("mid_ptr_restart", 200);

`ifdef UART_TX_ARB_LOCK_EN
    $display("[TB] message lock");
    do_reset();
    expect_grant(2'd1, 8'hA1);
    expect_grant(2'd1, 8'hA2);
    expect_grant(2'd1, 8'hA3);
    expect_grant(2'd0, 8'hB0);
    apply_stimulus(1, 8'hA1, 1'b0);
    apply_stimulus(1, 8'hA2, 1'b0);
    apply_stimulus(1, 8'hA3, 1'b1);
    @(negedge clk);
    apply_stimulus(0, 8'hB0, 1'b1);
    wait_idle("lock_done", 300);
`endif

    check_output("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
